// File: rtl/dm_pkg.sv
// Shared types and default widths for the data-memory arbiter slice.
package dm_pkg;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 8;
  localparam int STARVE_W = 4;

  typedef enum logic {SRC_CPU, SRC_EXT} dm_src_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } dm_req_t;

endpackage

// File: rtl/dm_starve_cnt.sv
// Saturating count of consecutive cycles the external port lost to the CPU;
// raises force_ext once the count reaches STARVE_MAX.
module dm_starve_cnt
  import dm_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic force_ext
);

  localparam logic [STARVE_W-1:0] CNT_MAX = STARVE_W'(STARVE_MAX);

  logic [STARVE_W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign force_ext = (cnt == CNT_MAX);

endmodule

// File: rtl/dm_arbiter.sv
// Single-port arbiter sharing the data memory between the CPU MEM stage and
// an external loader/debug port, with registered read return.
module dm_arbiter
  import dm_pkg::*;
#(
  parameter int ADDR_W     = dm_pkg::ADDR_W,
  parameter int DATA_W     = dm_pkg::DATA_W,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_read_data
);

  logic    force_ext;
  dm_req_t cpu_r, ext_r, sel_r;
  dm_src_t cur_src, last_src;
  logic    rd_valid_q;

  dm_starve_cnt #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (ext_req & cpu_gnt),
    .clr       (ext_gnt | ~ext_req),
    .force_ext (force_ext)
  );

  // CPU wins ties unless the external port has been starved long enough.
  assign ext_gnt   = ext_req & (~cpu_req | force_ext);
  assign cpu_gnt   = cpu_req & ~ext_gnt;
  assign cpu_stall = cpu_req & ~cpu_gnt;

  assign cpu_r   = '{we: cpu_we, addr: cpu_addr, wdata: cpu_wdata};
  assign ext_r   = '{we: ext_we, addr: ext_addr, wdata: ext_wdata};
  assign cur_src = ext_gnt ? SRC_EXT : SRC_CPU;

  // NOTE: defaulting every always_comb output first keeps the idle case
  // explicit (all zeros) and rules out inferred latches.
  always_comb begin
    sel_r = '0;
    if (ext_gnt) begin
      sel_r = ext_r;
    end else if (cpu_gnt) begin
      sel_r = cpu_r;
    end
  end

  assign mem_access_addr = sel_r.addr;
  assign mem_write_data  = sel_r.wdata;
  assign mem_write_en    = (cpu_gnt | ext_gnt) & sel_r.we;
  assign mem_read        = (cpu_gnt | ext_gnt) & ~sel_r.we;

  // Read data is latched into the owner's register at the edge closing the
  // grant cycle; last_src steers the one-cycle valid pulse afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_q <= 1'b0;
      last_src   <= SRC_CPU;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      rd_valid_q <= mem_read;
      last_src   <= cur_src;
      if (mem_read && cur_src == SRC_CPU) cpu_rdata <= mem_read_data;
      if (mem_read && cur_src == SRC_EXT) ext_rdata <= mem_read_data;
    end
  end

  assign cpu_rvalid = rd_valid_q & (last_src == SRC_CPU);
  assign ext_rvalid = rd_valid_q & (last_src == SRC_EXT);

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 256x8 memory attached.
module tb_dm_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_req, cpu_we;
  logic [7:0] cpu_addr, cpu_wdata;
  logic       cpu_gnt, cpu_stall, cpu_rvalid;
  logic [7:0] cpu_rdata;
  logic       ext_req, ext_we;
  logic [7:0] ext_addr, ext_wdata;
  logic       ext_gnt, ext_rvalid;
  logic [7:0] ext_rdata;
  logic [7:0] mem_access_addr, mem_write_data, mem_read_data;
  logic       mem_write_en, mem_read;

  logic [7:0] mem [256];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_W(8), .DATA_W(8), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(ext_gnt), .ext_rdata(ext_rdata), .ext_rvalid(ext_rvalid),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read(mem_read), .mem_read_data(mem_read_data)
  );

  assign mem_read_data = mem[mem_access_addr];
  always @(posedge clk) if (mem_write_en) mem[mem_access_addr] <= mem_write_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bit prev_cpu, prev_ext, exp_ext;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    mem[100] = 8'hFE;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ext_req = 0; ext_we = 0; ext_addr = 0; ext_wdata = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_ext_rvalid", ext_rvalid, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_ext_rdata", ext_rdata, 0);
    check("rst_starve", dut.u_starve.cnt, 0);
    check("rst_gnts", {cpu_gnt, ext_gnt, cpu_stall}, 0);
    check("rst_mem", {mem_read, mem_write_en, mem_access_addr, mem_write_data}, 0);
    rst_n = 1'b1;

    // CPU read of address 100
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'd100;
    #1;
    check("c1_cpu_gnt", cpu_gnt, 1);
    check("c1_mem_read", mem_read, 1);
    check("c1_addr", mem_access_addr, 100);
    check("c1_stall", cpu_stall, 0);
    @(negedge clk);
    cpu_req = 0;
    #1;
    check("c2_cpu_rvalid", cpu_rvalid, 1);
    check("c2_cpu_rdata", cpu_rdata, 8'hFE);
    check("c2_ext_rvalid", ext_rvalid, 0);

    // ext write 5A to 7, then ext read 7
    ext_req = 1; ext_we = 1; ext_addr = 8'd7; ext_wdata = 8'h5A;
    #1;
    check("ew_gnt", ext_gnt, 1);
    check("ew_we", mem_write_en, 1);
    check("ew_data", mem_write_data, 8'h5A);
    check("ew_rd", mem_read, 0);
    @(negedge clk);
    ext_we = 0;
    #1;
    check("er_mem_read", mem_read, 1);
    check("er_addr", mem_access_addr, 7);
    check("er_no_cpu_rvalid", cpu_rvalid, 0);
    check("ew_no_ext_rvalid", ext_rvalid, 0);
    @(negedge clk);
    ext_req = 0;
    #1;
    check("er_ext_rvalid", ext_rvalid, 1);
    check("er_ext_rdata", ext_rdata, 8'h5A);
    check("er_cpu_rvalid", cpu_rvalid, 0);
    check("er_cpu_rdata_hold", cpu_rdata, 8'hFE);
    check("idle_mem", {mem_read, mem_write_en, mem_access_addr, mem_write_data}, 0);
    check("idle_gnt", {cpu_gnt, ext_gnt}, 0);
    @(negedge clk);
    #1;
    check("idle_rvalid", {cpu_rvalid, ext_rvalid}, 0);

    // both ports request reads continuously: period-5 pattern
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'd100;
    ext_req = 1; ext_we = 0; ext_addr = 8'd7;
    prev_cpu = 0; prev_ext = 0;
    for (int k = 1; k <= 10; k++) begin
      exp_ext = (k % 5 == 0);
      #1;
      check($sformatf("st%0d_cpu_gnt", k), cpu_gnt, !exp_ext);
      check($sformatf("st%0d_ext_gnt", k), ext_gnt, exp_ext);
      check($sformatf("st%0d_stall", k), cpu_stall, exp_ext);
      check($sformatf("st%0d_cnt", k), dut.u_starve.cnt, (k - 1) % 5);
      check($sformatf("st%0d_rvalid", k), {cpu_rvalid, ext_rvalid}, {prev_cpu, prev_ext});
      if (exp_ext) check($sformatf("st%0d_addr", k), mem_access_addr, 7);
      prev_cpu = !exp_ext; prev_ext = exp_ext;
      @(negedge clk);
    end

    // only ext requests
    cpu_req = 0;
    for (int k = 1; k <= 4; k++) begin
      #1;
      check($sformatf("eo%0d_ext_gnt", k), ext_gnt, 1);
      check($sformatf("eo%0d_cnt", k), dut.u_starve.cnt, 0);
      check($sformatf("eo%0d_stall", k), cpu_stall, 0);
      check($sformatf("eo%0d_rvalid", k), {cpu_rvalid, ext_rvalid}, {prev_cpu, prev_ext});
      check($sformatf("eo%0d_rdata", k), ext_rdata, 8'h5A);
      prev_cpu = 0; prev_ext = 1;
      @(negedge clk);
    end
    ext_req = 0;
    #1;
    check("eo_last_rvalid", ext_rvalid, 1);
    check("eo_cnt_after", dut.u_starve.cnt, 0);

    // reset asserted during a CPU read grant drops the response
    mem[119] = 8'h77;
    @(negedge clk);
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'd119;
    #1;
    check("rr_cpu_gnt", cpu_gnt, 1);
    check("rr_rdata_before", cpu_rdata, 8'hFE);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    cpu_req = 0;
    @(negedge clk);
    #1;
    check("rr_cpu_rvalid", cpu_rvalid, 0);
    check("rr_cpu_rdata", cpu_rdata, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
